// File: rtl/turn_brake_ctrl_if.sv
// Lamp-controller signal bundle: driver requests in, lamp drive and
// indicator state out. The master side belongs to the driver-input decode,
// the slave side to turn_brake_ctrl.
interface turn_brake_ctrl_if;
    logic       brake;
    logic       turn_l;
    logic       turn_r;
    logic       hazard;
    logic       lamp_l;
    logic       lamp_r;
    logic [1:0] mode;
    logic       click;

    modport master (
        output brake, turn_l, turn_r, hazard,
        input  lamp_l, lamp_r, mode, click
    );

    modport slave (
        input  brake, turn_l, turn_r, hazard,
        output lamp_l, lamp_r, mode, click
    );
endinterface

// File: rtl/turn_brake_ctrl.sv
// turn_brake_ctrl: tail-light arbiter between brake, turn and hazard requests.
// A four-state FSM (IDLE/LEFT/RIGHT/HAZARD) selects the blinking side, and a
// 16-bit phase counter produces the BLINK_HALF on/off timing. Lamps, mode and
// click are registered and computed from the next state and next phase, so
// every output takes its new value at the same edge that samples the inputs.
// Optional feature macro: BRAKE_OVERRIDE_EN. When defined, brake holds both
// lamps on during hazard blinking. When undefined, hazard ignores brake.
module turn_brake_ctrl #(
    parameter int BLINK_HALF = 25
) (
    input logic              clk,
    input logic              rst,
    turn_brake_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LEFT   = 2'b01,
        ST_RIGHT  = 2'b10,
        ST_HAZARD = 2'b11
    } state_t;

    // Last count of a half-period; the counter wraps here and phase toggles.
    localparam logic [15:0] CNT_LAST = 16'(BLINK_HALF - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic        phase_r;
    logic        phase_nxt_s;
    logic        lamp_l_r;
    logic        lamp_r_r;
    logic        click_r;
    logic        lamp_l_s;
    logic        lamp_r_s;
    logic        click_s;

    // State, phase counter and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 16'd0;
            phase_r  <= 1'b0;
            lamp_l_r <= 1'b0;
            lamp_r_r <= 1'b0;
            click_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            phase_r  <= phase_nxt_s;
            lamp_l_r <= lamp_l_s;
            lamp_r_r <= lamp_r_s;
            click_r  <= click_s;
        end
    end

    // Next state from the request priority; both turns together with no hazard is treated as no request.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (bus.hazard) begin
            state_nxt_s = ST_HAZARD;
        end else if (bus.turn_l && !bus.turn_r) begin
            state_nxt_s = ST_LEFT;
        end else if (bus.turn_r && !bus.turn_l) begin
            state_nxt_s = ST_RIGHT;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // Next phase/count: idle parks dark, any entry restarts lit, otherwise count out the half-period.
    always_comb begin
        cnt_nxt_s   = 16'd0;
        phase_nxt_s = 1'b0;
        if (state_nxt_s == ST_IDLE) begin
            cnt_nxt_s   = 16'd0;
            phase_nxt_s = 1'b0;
        end else if (state_nxt_s != state_r) begin
            cnt_nxt_s   = 16'd0;
            phase_nxt_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = 16'd0;
            phase_nxt_s = ~phase_r;
        end else begin
            cnt_nxt_s   = cnt_r + 16'd1;
            phase_nxt_s = phase_r;
        end
    end

    // Lamp mapping and click from next state/phase; the non-blinking side always follows brake.
    always_comb begin
        lamp_l_s = 1'b0;
        lamp_r_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                lamp_l_s = bus.brake;
                lamp_r_s = bus.brake;
            end
            ST_LEFT: begin
                lamp_l_s = phase_nxt_s;
                lamp_r_s = bus.brake;
            end
            ST_RIGHT: begin
                lamp_l_s = bus.brake;
                lamp_r_s = phase_nxt_s;
            end
            ST_HAZARD: begin
`ifdef BRAKE_OVERRIDE_EN
                lamp_l_s = phase_nxt_s | bus.brake;
                lamp_r_s = phase_nxt_s | bus.brake;
`else
                lamp_l_s = phase_nxt_s;
                lamp_r_s = phase_nxt_s;
`endif
            end
            default: begin
                lamp_l_s = 1'b0;
                lamp_r_s = 1'b0;
            end
        endcase
        if (state_nxt_s == ST_IDLE) begin
            click_s = 1'b0;
        end else begin
            click_s = (state_nxt_s != state_r) || (phase_nxt_s && !phase_r);
        end
    end

    assign bus.lamp_l = lamp_l_r;
    assign bus.lamp_r = lamp_r_r;
    assign bus.mode   = state_r;
    assign bus.click  = click_r;

endmodule

// File: tb/tb_turn_brake_ctrl.sv
// Directed bench for turn_brake_ctrl with BLINK_HALF=4 (8-cycle blink period).
// Expected values are hand-derived from the blink waveform rules; hazard
// expectations follow BRAKE_OVERRIDE_EN when the build defines it.
module tb_turn_brake_ctrl;

    localparam int HALF = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    turn_brake_ctrl_if bus ();

    turn_brake_ctrl #(.BLINK_HALF(HALF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic tl, input logic tr, input logic hz);
        bus.brake  = b;
        bus.turn_l = tl;
        bus.turn_r = tr;
        bus.hazard = hz;
    endtask

    task automatic check_out(input string tag, input logic el, input logic er,
                             input logic [1:0] em, input logic ec);
        check_val({tag, ".lamp_l"}, {31'd0, bus.lamp_l}, {31'd0, el});
        check_val({tag, ".lamp_r"}, {31'd0, bus.lamp_r}, {31'd0, er});
        check_val({tag, ".mode"},   {30'd0, bus.mode},   {30'd0, em});
        check_val({tag, ".click"},  {31'd0, bus.click},  {31'd0, ec});
    endtask

    initial begin
        logic hz_lamp;
        n_checks = 0;
        n_errors = 0;

        // Reset with random inputs, outputs must be clear.
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (3) tick();
        check_out("reset", 1'b0, 1'b0, 2'b00, 1'b0);
        #4;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_out("idle", 1'b0, 1'b0, 2'b00, 1'b0);
        end

        // Brake only: both lamps steady, no blinking.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out("brake", 1'b1, 1'b1, 2'b00, 1'b0);
        end

        // Left turn with brake: lamp_l 1111 0000 x2, clicks at 0 and 8.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check_out("left_brake", ((k % 8) < 4), 1'b1, 2'b01, ((k % 8) == 0));
        end

        // Drop request during on phase: lamp goes dark at the next edge.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("drop", 1'b0, 1'b0, 2'b00, 1'b0);

        // Direction swap: 6 cycles left, then right restarts lit.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out("pre_swap", (k < 4), 1'b0, 2'b01, (k == 0));
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_out("swap", 1'b0, (k < 4), 2'b10, (k == 0));
        end

        // Hazard beats turn_l, brake applied.
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
`ifdef BRAKE_OVERRIDE_EN
            hz_lamp = 1'b1;
`else
            hz_lamp = (k < 4);
`endif
            check_out("hazard", hz_lamp, hz_lamp, 2'b11, (k == 0));
        end

        // Release hazard: left restarts lit, right follows brake.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_out("hz_release", 1'b1, 1'b1, 2'b01, 1'b1);

        // Invalid both-turns maps to idle, lamps follow brake.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("invalid_brk", 1'b1, 1'b1, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("invalid", 1'b0, 1'b0, 2'b00, 1'b0);

        // Reset mid on-phase: asynchronous clear, then clean restart.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        check_out("pre_rst", 1'b1, 1'b0, 2'b01, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_out("rst_async", 1'b0, 1'b0, 2'b00, 1'b0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_out("post_rst", ((k % 8) < 4), 1'b0, 2'b01, ((k % 8) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/turn_brake_ctrl.md
# turn_brake_ctrl

Indicator-lamp controller for the tail-light subsystem. Arbitrates the shared left and right rear lamps between the brake request and the turn and hazard requests. Generates the blink timing from the system clock with a phase counter. Drives the two lamp outputs and a click pulse for the audible indicator, and sits between the driver-input decode and the lamp driver stage.

## Interface
- BLINK_HALF, default 25: clock cycles per blink half-period (on time = off time); legal range 2..65535.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- brake  input  1  brake pedal request, level.
- turn_l  input  1  left-turn request, level.
- turn_r  input  1  right-turn request, level.
- hazard  input  1  hazard request, level.
- lamp_l  output  1  left rear lamp, registered.
- lamp_r  output  1  right rear lamp, registered.
- mode  output  2  current state: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.
- click  output  1  one-cycle pulse on each lamp off→on blink edge, registered.

## Operation
- FSM states IDLE, LEFT, RIGHT, HAZARD. Next state is evaluated every cycle from the sampled inputs in priority order:
  - hazard=1 → HAZARD.
  - else turn_l=1, turn_r=0 → LEFT.
  - else turn_r=1, turn_l=0 → RIGHT.
  - else IDLE. turn_l=turn_r=1 without hazard is invalid and maps to IDLE.
- Phase logic: 16-bit counter cnt and a 1-bit phase.
  - In IDLE: cnt=0, phase=0.
  - On any state change into LEFT, RIGHT or HAZARD (including LEFT↔RIGHT): cnt=0 and phase=1, so the lamp lights on the entry edge.
  - Otherwise in a blinking state: cnt increments. When cnt reaches BLINK_HALF-1 it wraps to 0 and phase toggles.
- Lamp mapping, computed from next state and next phase:
  - IDLE: lamp_l=lamp_r=brake.
  - LEFT: lamp_l=phase, lamp_r=brake.
  - RIGHT: lamp_r=phase, lamp_l=brake.
  - HAZARD: lamp_l=lamp_r=phase; brake handling is set by the macro in Configuration.
- click=1 for exactly one cycle when next phase goes 0→1 inside an unchanged blinking state, and also on entry into a blinking state.
- Brake never affects the FSM, cnt or phase; it changes only the lamp mapping.

## Timing
- Reset values: state IDLE, mode=00, cnt=0, phase=0, lamp_l=0, lamp_r=0, click=0.
- Latency: inputs sampled at edge N. State, mode, lamps and click all take their new values at edge N, visible after edge N (one register stage).
- Blink waveform: after entry to LEFT at edge N:
  - lamp_l=1 for edges N..N+BLINK_HALF-1.
  - lamp_l=0 for edges N+BLINK_HALF..N+2·BLINK_HALF-1.
  - the pattern then repeats, and click is asserted at edges N, N+2·BLINK_HALF, and so on.
- Request held while state unchanged: the blink period is exactly 2·BLINK_HALF cycles with no drift.
- A request that drops during the on phase extinguishes the lamp (or returns it to the brake level) at the next edge. There is no minimum flash length.
- LEFT→RIGHT directly: the new side restarts lit at the change edge. The old side follows brake from the same edge.
- Reset asserted mid-blink: outputs clear immediately (asynchronously). After release, operation resumes from IDLE at the first clock edge.

## Configuration
- BRAKE_OVERRIDE_EN:
  - Defined: in HAZARD, lamp_l=lamp_r=phase|brake, so brake holds both lamps steady on while hazard blinking continues internally. click is unchanged.
  - Undefined: in HAZARD, brake is ignored and lamp_l=lamp_r=phase.

## Test plan
- Reset: rst=1 with random inputs → lamp_l=lamp_r=click=0, mode=00. Release rst, hold all inputs 0 for 20 cycles → outputs stay 0.
- Brake only, BLINK_HALF=4: brake=1 for 10 cycles → lamp_l=lamp_r=1 from the first sampling edge. mode stays 00, click never asserted.
- Left turn with brake, BLINK_HALF=4: turn_l=1, brake=1 held 16 cycles → lamp_l pattern 1111 0000 1111 0000, lamp_r=1 constant, click pulses at cycles 0 and 8, mode=01.
- Direction swap: turn_l=1 for 6 cycles, then turn_r=1, turn_l=0 → at the swap edge lamp_r=1, lamp_l=0, click=1, mode=10. lamp_r stays on for 4 cycles.
- Hazard with brake and priority: hazard=1, turn_l=1, brake=1 → mode=11. Without BRAKE_OVERRIDE_EN both lamps blink 1111 0000. With the macro defined both lamps are constant 1. Release hazard → mode=01 and lamp_l restarts lit.
- Invalid and reset-in-flight: turn_l=turn_r=1 → mode=00, lamps=brake. Assert rst during the on phase of LEFT → lamps drop with no clock edge required, and cnt is observed as 0 after release.
